cnn_mem_ctrl: RTL and testbench

Arbiter and sequencer in front of the single-port CNN byte RAM (parameters and image). It shares the RAM between the host Avalon-MM slave port and the CNN compute engine using round-robin arbitration with wait states. It also exposes a small control/status register space so that software can start the engine and poll for completion. It sits between the HPS bridge and the RAM macro; the engine sees only a req/gnt port.

---
 rtl/cnn_mem_pkg.sv | 30 +++
 rtl/cnn_mem_rr_arb.sv | 44 ++++
 rtl/cnn_mem_ctrl.sv | 172 +++++++++++++++++
 tb/tb_cnn_mem_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_mem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// cnn_mem_pkg : shared types and register map for cnn_mem_ctrl
// Rev 1.0
// ----------------------------------------------------------------
package cnn_mem_pkg;

   typedef enum logic {
      GNT_HOST   = 1'b0,
      GNT_ENGINE = 1'b1
   } grant_e;

   typedef enum logic [1:0] {
      H_IDLE    = 2'd0,
      H_RD_WAIT = 2'd1,
      H_RD_DATA = 2'd2
   } host_state_e;

   localparam int unsigned REG_CTRL   = 0;
   localparam int unsigned REG_STATUS = 1;

   localparam int unsigned CTRL_START_BIT = 0;
   localparam int unsigned CTRL_CLEAR_BIT = 1;

   localparam int unsigned STAT_BUSY_BIT = 0;
   localparam int unsigned STAT_DONE_BIT = 1;
   localparam int unsigned STAT_ERR_BIT  = 2;

endpackage
`default_nettype wire

// File: rtl/cnn_mem_rr_arb.sv
`default_nettype none
// ----------------------------------------------------------------
// cnn_mem_rr_arb : two-way round-robin arbiter, host vs engine
// Rev 1.0
// ----------------------------------------------------------------
module cnn_mem_rr_arb
   import cnn_mem_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic i_host_req,
   input  logic i_eng_req,
   output logic o_host_gnt,
   output logic o_eng_gnt
);

   grant_e r_last_grant;

   // Grants are suppressed during reset so no RAM access leaks out.
   always_comb begin
      o_host_gnt = 1'b0;
      o_eng_gnt  = 1'b0;
      if (!reset) begin
         if (i_host_req && i_eng_req) begin
            o_host_gnt = (r_last_grant == GNT_ENGINE);
            o_eng_gnt  = (r_last_grant == GNT_HOST);
         end else begin
            o_host_gnt = i_host_req;
            o_eng_gnt  = i_eng_req;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_last_grant <= GNT_ENGINE;
      else if (o_host_gnt)
         r_last_grant <= GNT_HOST;
      else if (o_eng_gnt)
         r_last_grant <= GNT_ENGINE;
   end

endmodule
`default_nettype wire

// File: rtl/cnn_mem_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------
// cnn_mem_ctrl : shares the CNN byte RAM between host and engine,
//                plus start/status registers. Rev 1.0
// ----------------------------------------------------------------
module cnn_mem_ctrl
   import cnn_mem_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              i_chipselect,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W:0]   i_address,
   input  logic [DATA_W-1:0] i_writedata,
   output logic [DATA_W-1:0] o_readdata,
   output logic              o_waitrequest,
   input  logic              i_eng_req,
   input  logic              i_eng_we,
   input  logic [ADDR_W-1:0] i_eng_addr,
   input  logic [DATA_W-1:0] i_eng_wdata,
   output logic              o_eng_gnt,
   output logic              o_eng_rvalid,
   output logic [DATA_W-1:0] o_eng_rdata,
   output logic              o_eng_start,
   input  logic              i_eng_done,
   output logic              o_mem_en,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   input  logic [DATA_W-1:0] i_mem_rdata
);

   host_state_e       r_state;
   host_state_e       w_state_nxt;
   logic [DATA_W-1:0] r_readdata;
   logic              r_eng_rvalid;
   logic              r_eng_start;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic [DATA_W-1:0] w_status;
   logic [DATA_W-1:0] w_reg_rdata;

   // A simultaneous read+write strobe is treated as a read.
   wire w_idle      = (r_state == H_IDLE);
   wire w_host_sel  = w_idle && i_chipselect && (i_read || i_write);
   wire w_reg_sel   = i_address[ADDR_W];
   wire w_host_rd   = i_read;
   wire w_host_wr   = i_write && !i_read;
   wire w_host_req  = w_host_sel && !w_reg_sel;
   wire w_reg_rd    = w_host_sel && w_reg_sel && w_host_rd;
   wire w_reg_wr    = w_host_sel && w_reg_sel && w_host_wr;
   wire w_ctrl_hit  = (i_address[ADDR_W-1:0] == ADDR_W'(REG_CTRL));
   wire w_stat_hit  = (i_address[ADDR_W-1:0] == ADDR_W'(REG_STATUS));
   wire w_start_req = w_reg_wr && w_ctrl_hit && i_writedata[CTRL_START_BIT];
   wire w_clear_req = w_reg_wr && w_ctrl_hit && i_writedata[CTRL_CLEAR_BIT];
   wire w_host_gnt;
   wire w_eng_gnt;

   cnn_mem_rr_arb u_arb (
      .clk        (clk),
      .reset      (reset),
      .i_host_req (w_host_req),
      .i_eng_req  (i_eng_req),
      .o_host_gnt (w_host_gnt),
      .o_eng_gnt  (w_eng_gnt)
   );

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= H_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         H_IDLE: begin
            if (w_reg_rd)
               w_state_nxt = H_RD_DATA;
            else if (w_host_gnt && w_host_rd)
               w_state_nxt = H_RD_WAIT;
         end
         H_RD_WAIT: w_state_nxt = H_RD_DATA;
         H_RD_DATA: w_state_nxt = H_IDLE;
         default:   w_state_nxt = H_IDLE;
      endcase
   end

   always_comb begin
      o_waitrequest = 1'b0;
      o_mem_en      = 1'b0;
      o_mem_we      = 1'b0;
      o_mem_addr    = i_eng_addr;
      o_mem_wdata   = i_eng_wdata;
      case (r_state)
         H_IDLE: begin
            if (w_host_sel)
               o_waitrequest = w_reg_sel ? w_host_rd : (w_host_rd || !w_host_gnt);
         end
         H_RD_WAIT: o_waitrequest = 1'b1;
         default:   o_waitrequest = 1'b0;
      endcase
      if (w_host_gnt) begin
         o_mem_en    = 1'b1;
         o_mem_we    = w_host_wr;
         o_mem_addr  = i_address[ADDR_W-1:0];
         o_mem_wdata = i_writedata;
      end else if (w_eng_gnt) begin
         o_mem_en    = 1'b1;
         o_mem_we    = i_eng_we;
      end
   end

   always_comb begin
      w_status                = '0;
      w_status[STAT_BUSY_BIT] = r_busy;
      w_status[STAT_DONE_BIT] = r_done;
      w_status[STAT_ERR_BIT]  = r_err;
      w_reg_rdata             = w_stat_hit ? w_status : '0;
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_readdata <= '0;
      else if (r_state == H_RD_WAIT)
         r_readdata <= i_mem_rdata;
      else if (w_reg_rd)
         r_readdata <= w_reg_rdata;
   end

   // Later assignments win: clear, then reject/accept start against the old busy.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_eng_start  <= 1'b0;
         r_eng_rvalid <= 1'b0;
      end else begin
         r_eng_start  <= w_start_req && !r_busy;
         r_eng_rvalid <= w_eng_gnt && !i_eng_we;
         if (w_clear_req) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
         end
         if (w_start_req && r_busy)
            r_err <= 1'b1;
         if (i_eng_done) begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
         end
         if (w_start_req && !r_busy) begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
         end
      end
   end

   assign o_readdata   = r_readdata;
   assign o_eng_gnt    = w_eng_gnt;
   assign o_eng_rvalid = r_eng_rvalid;
   assign o_eng_rdata  = i_mem_rdata;
   assign o_eng_start  = r_eng_start;

endmodule
`default_nettype wire

// File: tb/tb_cnn_mem_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------
// tb_cnn_mem_ctrl : transaction-level reference model bench
// Rev 1.0
// ----------------------------------------------------------------
module tb_cnn_mem_ctrl;

   localparam int ADDR_W = 10;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              reset;
   logic              chipselect, read, write;
   logic [ADDR_W:0]   address;
   logic [DATA_W-1:0] writedata, readdata;
   logic              waitrequest;
   logic              eng_req, eng_we;
   logic [ADDR_W-1:0] eng_addr;
   logic [DATA_W-1:0] eng_wdata, eng_rdata;
   logic              eng_gnt, eng_rvalid, eng_start, eng_done;
   logic              mem_en, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   cnn_mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .reset(reset),
      .i_chipselect(chipselect), .i_read(read), .i_write(write),
      .i_address(address), .i_writedata(writedata),
      .o_readdata(readdata), .o_waitrequest(waitrequest),
      .i_eng_req(eng_req), .i_eng_we(eng_we), .i_eng_addr(eng_addr),
      .i_eng_wdata(eng_wdata), .o_eng_gnt(eng_gnt), .o_eng_rvalid(eng_rvalid),
      .o_eng_rdata(eng_rdata), .o_eng_start(eng_start), .i_eng_done(eng_done),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
   );

   // Single-port RAM macro with one-cycle read latency
   logic [7:0] ram [1024];
   logic [7:0] ram_q;
   logic       ram_init = 1'b0;

   function automatic logic [7:0] init_byte(input int i);
      return 8'((i * 37 + 11) & 255);
   endfunction

   always @(posedge clk) begin
      if (ram_init) begin
         for (int i = 0; i < 1024; i++) ram[i] <= init_byte(i);
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        ram_q <= ram[mem_addr];
      end
   end
   assign mem_rdata = ram_q;

   // Reference model state
   typedef enum int {HN, HRW, HRR, HGW, HGR} hop_e;
   hop_e       h_op = HN;
   logic [10:0] h_addr = '0;
   logic [7:0] h_wd = '0, h_exp_rd = '0, last_rd = '0;
   int         h_phase = 0;
   logic [9:0] eq_addr[$];
   bit         eq_we[$];
   logic [7:0] eq_wd[$];
   logic [7:0] mem_m [1024];
   bit         m_busy, m_done, m_err, m_last_host;
   bit         start_exp, rv_exp, done_pulse, rand_eng;
   logic [7:0] rv_data;

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] status_m();
      return {5'd0, m_err, m_done, m_busy};
   endfunction

   task automatic push_eng(input bit we, input logic [9:0] a, input logic [7:0] d);
      eq_we.push_back(we);
      eq_addr.push_back(a);
      eq_wd.push_back(d);
   endtask

   // One clock: drive intents, check outputs against model, advance model.
   task automatic cycle();
      bit e_act, h_ram, hg, eg, exp_wait, start, clear;
      if (rand_eng && $urandom_range(0, 2) == 0)
         push_eng(1'($urandom_range(0, 1)), 10'($urandom_range(0, 31)), 8'($urandom));
      if (rand_eng && m_busy && $urandom_range(0, 7) == 0)
         done_pulse = 1'b1;
      e_act      = (eq_addr.size() > 0);
      chipselect = (h_op != HN);
      read       = (h_op == HRR) || (h_op == HGR);
      write      = (h_op == HRW) || (h_op == HGW);
      address    = h_addr;
      writedata  = h_wd;
      eng_req    = e_act;
      eng_we     = e_act ? eq_we[0] : 1'b0;
      eng_addr   = e_act ? eq_addr[0] : '0;
      eng_wdata  = e_act ? eq_wd[0] : '0;
      eng_done   = done_pulse;
      #1;
      h_ram = ((h_op == HRW) || (h_op == HRR)) && (h_phase == 0);
      hg    = h_ram && (!e_act || !m_last_host);
      eg    = e_act && !hg;
      if (h_phase == 2)      exp_wait = 1'b1;
      else if (h_phase == 1) exp_wait = 1'b0;
      else case (h_op)
         HRW:     exp_wait = !hg;
         HRR:     exp_wait = 1'b1;
         HGR:     exp_wait = 1'b1;
         default: exp_wait = 1'b0;
      endcase
      check_val("waitrequest", waitrequest, exp_wait);
      check_val("eng_gnt", eng_gnt, eg);
      check_val("mem_en", mem_en, hg || eg);
      check_val("eng_rvalid", eng_rvalid, rv_exp);
      check_val("eng_start", eng_start, start_exp);
      if (rv_exp) check_val("eng_rdata", eng_rdata, rv_data);
      if (hg) begin
         check_val("host_mem_addr", mem_addr, h_addr[9:0]);
         check_val("host_mem_we", mem_we, h_op == HRW);
         if (h_op == HRW) check_val("host_mem_wdata", mem_wdata, h_wd);
      end
      if (eg) begin
         check_val("eng_mem_addr", mem_addr, eq_addr[0]);
         check_val("eng_mem_we", mem_we, eq_we[0]);
         if (eq_we[0]) check_val("eng_mem_wdata", mem_wdata, eq_wd[0]);
      end
      if (h_phase == 1) begin
         last_rd = readdata;
         check_val("readdata", readdata, h_exp_rd);
      end
      // advance the model to the state after this clock edge
      start  = (h_op == HGW) && (h_phase == 0) && (h_addr[9:0] == 10'd0) && h_wd[0];
      clear  = (h_op == HGW) && (h_phase == 0) && (h_addr[9:0] == 10'd0) && h_wd[1];
      rv_exp = 1'b0;
      if (eg) begin
         if (eq_we[0]) mem_m[eq_addr[0]] = eq_wd[0];
         else begin rv_exp = 1'b1; rv_data = mem_m[eq_addr[0]]; end
         void'(eq_we.pop_front()); void'(eq_addr.pop_front()); void'(eq_wd.pop_front());
         m_last_host = 1'b0;
      end
      if (hg) begin
         m_last_host = 1'b1;
         if (h_op == HRW) begin mem_m[h_addr[9:0]] = h_wd; h_op = HN; end
         else begin h_exp_rd = mem_m[h_addr[9:0]]; h_phase = 2; end
      end else if (h_phase == 2) h_phase = 1;
      else if (h_phase == 1) begin h_phase = 0; h_op = HN; end
      else if (h_op == HGR) begin
         h_exp_rd = (h_addr[9:0] == 10'd1) ? status_m() : 8'd0;
         h_phase  = 1;
      end else if (h_op == HGW) h_op = HN;
      start_exp = start && !m_busy;
      if (clear) begin m_done = 1'b0; m_err = 1'b0; end
      if (start && m_busy) m_err = 1'b1;
      if (done_pulse) begin m_busy = 1'b0; m_done = 1'b1; end
      if (start_exp) begin m_busy = 1'b1; m_done = 1'b0; end
      done_pulse = 1'b0;
      @(negedge clk);
   endtask

   task automatic host_do(input hop_e op, input logic [10:0] a, input logic [7:0] d, output int ncyc);
      h_op = op; h_addr = a; h_wd = d; ncyc = 0;
      while (h_op != HN) begin cycle(); ncyc++; end
   endtask

   task automatic drain();
      while (eq_addr.size() > 0) cycle();
      cycle();
   endtask

   task automatic apply_reset(input bit keep_req, input bit first);
      reset = 1'b1;
      ram_init = first;
      eng_done = 1'b0;
      if (!keep_req) begin
         chipselect = 1'b0; read = 1'b0; write = 1'b0; eng_req = 1'b0;
         address = '0; writedata = '0; eng_we = 1'b0; eng_addr = '0; eng_wdata = '0;
      end else begin
         eng_req = 1'b1; eng_we = 1'b0; eng_addr = 10'd3;
      end
      #1;
      check_val("rst_cycle_mem_en", mem_en, 1'b0);
      check_val("rst_cycle_eng_gnt", eng_gnt, 1'b0);
      @(negedge clk);
      reset = 1'b0; ram_init = 1'b0;
      chipselect = 1'b0; read = 1'b0; write = 1'b0; eng_req = 1'b0;
      h_op = HN; h_phase = 0; m_busy = 0; m_done = 0; m_err = 0; m_last_host = 0;
      start_exp = 0; rv_exp = 0; done_pulse = 0;
      eq_addr.delete(); eq_we.delete(); eq_wd.delete();
      if (first) for (int i = 0; i < 1024; i++) mem_m[i] = init_byte(i);
      #1;
      check_val("rst_waitrequest", waitrequest, 1'b0);
      check_val("rst_eng_rvalid", eng_rvalid, 1'b0);
      check_val("rst_eng_start", eng_start, 1'b0);
      check_val("rst_readdata", readdata, 8'h00);
      check_val("rst_mem_en", mem_en, 1'b0);
   endtask

   initial begin
      int n, k;
      reset = 1'b1; chipselect = 0; read = 0; write = 0; address = '0; writedata = '0;
      eng_req = 0; eng_we = 0; eng_addr = '0; eng_wdata = '0; eng_done = 0;
      rand_eng = 1'b0;
      @(negedge clk);
      apply_reset(1'b0, 1'b1);
      host_do(HGR, 11'h401, 8'h00, n);
      check_val("status_after_reset", last_rd, 8'h00);

      // zero-wait write, then 2-wait-state read back
      host_do(HRW, 11'h010, 8'hA5, n);
      check_val("ram_wr_cycles", n, 1);
      host_do(HRR, 11'h010, 8'h00, n);
      check_val("ram_rd_cycles", n, 3);
      check_val("ram_rd_data", last_rd, 8'hA5);

      // collisions from reset: host first, then alternation
      apply_reset(1'b0, 1'b0);
      push_eng(1'b1, 10'h020, 8'h3C);
      host_do(HRW, 11'h021, 8'h11, n);
      check_val("coll_host_first", n, 1);
      push_eng(1'b1, 10'h022, 8'h5A);
      host_do(HRW, 11'h023, 8'h22, n);
      check_val("coll_alternate", n, 2);
      drain();

      // engine back-to-back reads alongside a host read
      push_eng(1'b0, 10'd0, 8'h00);
      push_eng(1'b0, 10'd1, 8'h00);
      push_eng(1'b0, 10'd2, 8'h00);
      host_do(HRR, 11'h005, 8'h00, n);
      drain();
      host_do(HRR, 11'h020, 8'h00, n);
      check_val("eng_write_seen", last_rd, 8'h3C);

      // start / done / error handling
      host_do(HGW, 11'h400, 8'h01, n);
      check_val("ctrl_wr_cycles", n, 1);
      host_do(HGR, 11'h401, 8'h00, n);
      check_val("status_busy", last_rd, 8'h01);
      check_val("reg_rd_cycles", n, 2);
      done_pulse = 1'b1; cycle();
      host_do(HGR, 11'h401, 8'h00, n);
      check_val("status_done", last_rd, 8'h02);
      host_do(HGW, 11'h400, 8'h01, n);
      host_do(HGW, 11'h400, 8'h01, n);
      host_do(HGR, 11'h401, 8'h00, n);
      check_val("status_err", last_rd, 8'h05);
      host_do(HGW, 11'h400, 8'h02, n);
      host_do(HGR, 11'h401, 8'h00, n);
      check_val("status_cleared", last_rd, 8'h01);
      done_pulse = 1'b1;
      host_do(HGW, 11'h400, 8'h01, n);
      host_do(HGR, 11'h401, 8'h00, n);
      check_val("status_done_vs_start", last_rd, 8'h06);
      host_do(HGW, 11'h400, 8'h03, n);
      host_do(HGR, 11'h401, 8'h00, n);
      check_val("status_clear_then_start", last_rd, 8'h01);
      host_do(HGR, 11'h402, 8'h00, n);
      check_val("unmapped_reg", last_rd, 8'h00);

      // reset while the host read is in its wait state and engine busy
      h_op = HRR; h_addr = 11'h005;
      cycle();
      apply_reset(1'b1, 1'b0);
      host_do(HGR, 11'h401, 8'h00, n);
      check_val("status_after_midreset", last_rd, 8'h00);
      host_do(HRR, 11'h010, 8'h00, n);
      check_val("rd_after_midreset", n, 3);

      // randomized traffic
      rand_eng = 1'b1;
      for (int t = 0; t < 400; t++) begin
         k = $urandom_range(0, 9);
         case (k)
            0, 1, 2: host_do(HRW, {1'b0, 10'($urandom_range(0, 31))}, 8'($urandom), n);
            3, 4, 5: host_do(HRR, {1'b0, 10'($urandom_range(0, 31))}, 8'h00, n);
            6:       host_do(HGW, {1'b1, 10'($urandom_range(0, 3))}, 8'($urandom_range(0, 3)), n);
            7:       host_do(HGR, {1'b1, 10'($urandom_range(0, 3))}, 8'h00, n);
            default: cycle();
         endcase
      end
      rand_eng = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
`default_nettype wire
